// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Register file with scoreboard for the pipelined core.
//
// Holds 2**ADDR_W registers of DATA_W bits. Two combinational read ports and
// one clocked write port. Each register carries a pending bit: decode sets it
// when an instruction targeting that register issues, writeback clears it.
// The busy outputs let hazard logic stall on an outstanding producer.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   register address width, depth = 2**ADDR_W
//   ZERO_REG 1: register 0 reads as 0, is never written, never pending
//   BYPASS   1: a same-cycle write is forwarded to the read ports
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active-high
//   RN1/RN2   in   read addresses
//   RD1/RD2   out  read data (combinational)
//   busy1/2   out  addressed register has an outstanding producer
//   issue_en  in   mark issue_wn pending at the next edge
//   issue_wn  in   destination register being issued
//   RegWrite  in   writeback enable
//   WN        in   writeback register address
//   WD        in   writeback data
//   pend_cnt  out  number of pending registers (registered)
// -----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] RN1,
   input  logic [ADDR_W-1:0] RN2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              busy1,
   output logic              busy2,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_wn,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WN,
   input  logic [DATA_W-1:0] WD,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [DEPTH-1:0]  ONE_HOT_0 = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_pend;
   logic [ADDR_W:0]   r_cnt;

   logic              w_we;
   logic              w_set;
   logic              w_inc;
   logic              w_dec;
   logic [DEPTH-1:0]  w_set_vec;
   logic [DEPTH-1:0]  w_clr_vec;
   logic [DEPTH-1:0]  w_pend_nxt;
   logic [ADDR_W:0]   w_cnt_nxt;
   logic              w_zero1;
   logic              w_zero2;
   logic              w_byp1;
   logic              w_byp2;

   // Qualify write and issue requests (register 0 is inert when hard-wired).
   always_comb begin
      w_we  = 1'b0;
      w_set = 1'b0;
      if ((ZERO_REG != 0) && (WN == ADDR_ZERO)) begin
         w_we = 1'b0;
      end else begin
         w_we = RegWrite;
      end
      if ((ZERO_REG != 0) && (issue_wn == ADDR_ZERO)) begin
         w_set = 1'b0;
      end else begin
         w_set = issue_en;
      end
   end

   // Next pending vector and population-count delta.
   always_comb begin
      w_set_vec  = {DEPTH{1'b0}};
      w_clr_vec  = {DEPTH{1'b0}};
      w_inc      = 1'b0;
      w_dec      = 1'b0;
      w_cnt_nxt  = r_cnt;
      if (w_set) begin
         w_set_vec = ONE_HOT_0 << issue_wn;
      end else begin
         w_set_vec = {DEPTH{1'b0}};
      end
      if (w_we) begin
         w_clr_vec = ONE_HOT_0 << WN;
      end else begin
         w_clr_vec = {DEPTH{1'b0}};
      end
      // Set is OR-ed after the clear so a re-issue of the register being
      // written back leaves it pending for the newer producer.
      w_pend_nxt = (r_pend & ~w_clr_vec) | w_set_vec;
      // Count only real transitions: duplicate issues and writebacks to
      // non-pending registers leave the count alone.
      w_inc = w_set & ~r_pend[issue_wn];
      w_dec = w_we & r_pend[WN] & ~(w_set & (issue_wn == WN));
      if (w_inc && !w_dec) begin
         w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
      end else if (w_dec && !w_inc) begin
         w_cnt_nxt = r_cnt - {{ADDR_W{1'b0}}, 1'b1};
      end else begin
         w_cnt_nxt = r_cnt;
      end
   end

   // Register array: cleared on reset so no output ever carries X.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= DATA_ZERO;
         end
      end else begin
         if (w_we) begin
            r_mem[WN] <= WD;
         end
      end
   end

   // Pending bits and their registered population count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= {DEPTH{1'b0}};
         r_cnt  <= {(ADDR_W+1){1'b0}};
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   // Read-port override decode (zero register beats bypass).
   always_comb begin
      w_zero1 = (ZERO_REG != 0) && (RN1 == ADDR_ZERO);
      w_zero2 = (ZERO_REG != 0) && (RN2 == ADDR_ZERO);
      w_byp1  = (BYPASS != 0) && w_we && (WN == RN1);
      w_byp2  = (BYPASS != 0) && w_we && (WN == RN2);
   end

   // Read data and busy; reset is gated in so a bypassed WD cannot leak out.
   always_comb begin
      RD1   = DATA_ZERO;
      RD2   = DATA_ZERO;
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (rst || w_zero1) begin
         RD1   = DATA_ZERO;
         busy1 = 1'b0;
      end else if (w_byp1) begin
         RD1   = WD;
         busy1 = 1'b0;
      end else begin
         RD1   = r_mem[RN1];
         busy1 = r_pend[RN1];
      end
      if (rst || w_zero2) begin
         RD2   = DATA_ZERO;
         busy2 = 1'b0;
      end else if (w_byp2) begin
         RD2   = WD;
         busy2 = 1'b0;
      end else begin
         RD2   = r_mem[RN2];
         busy2 = r_pend[RN2];
      end
   end

   assign pend_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Directed bench for reg_file_sb. Three instances share one stimulus stream:
//   u_a : defaults (ZERO_REG=1, BYPASS=1, ADDR_W=5)
//   u_b : ZERO_REG=0, BYPASS=0
//   u_c : ADDR_W=3, ZERO_REG=1, BYPASS=1 (saturation)
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after that, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic        clk;
   logic        rst;
   logic [4:0]  rn1, rn2, issue_wn, wn;
   logic        issue_en, regwrite;
   logic [31:0] wd;

   logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, rd1_c, rd2_c;
   logic        busy1_a, busy2_a, busy1_b, busy2_b, busy1_c, busy2_c;
   logic [5:0]  pend_a, pend_b;
   logic [3:0]  pend_c;

   int checks = 0;
   int errors = 0;

   reg_file_sb u_a (
      .clk(clk), .rst(rst), .RN1(rn1), .RN2(rn2), .RD1(rd1_a), .RD2(rd2_a),
      .busy1(busy1_a), .busy2(busy2_a), .issue_en(issue_en), .issue_wn(issue_wn),
      .RegWrite(regwrite), .WN(wn), .WD(wd), .pend_cnt(pend_a)
   );

   reg_file_sb #(.ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .rst(rst), .RN1(rn1), .RN2(rn2), .RD1(rd1_b), .RD2(rd2_b),
      .busy1(busy1_b), .busy2(busy2_b), .issue_en(issue_en), .issue_wn(issue_wn),
      .RegWrite(regwrite), .WN(wn), .WD(wd), .pend_cnt(pend_b)
   );

   reg_file_sb #(.ADDR_W(3)) u_c (
      .clk(clk), .rst(rst), .RN1(rn1[2:0]), .RN2(rn2[2:0]), .RD1(rd1_c), .RD2(rd2_c),
      .busy1(busy1_c), .busy2(busy2_c), .issue_en(issue_en), .issue_wn(issue_wn[2:0]),
      .RegWrite(regwrite), .WN(wn[2:0]), .WD(wd), .pend_cnt(pend_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_en = 1'b0;
      regwrite = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rn1 = 5'd0; rn2 = 5'd0; issue_en = 1'b0; issue_wn = 5'd0;
      regwrite = 1'b0; wn = 5'd0; wd = 32'd0;
      tick();

      // Reset held: bypass must not leak, counts zero
      regwrite = 1'b1; wn = 5'd5; wd = 32'hFFFF_FFFF; rn1 = 5'd5;
      #1;
      chk("rst_held_rd1", rd1_a, 32'd0);
      chk("rst_held_busy1", {31'd0, busy1_a}, 32'd0);
      chk("rst_held_cnt", {26'd0, pend_a}, 32'd0);
      idle();
      rst = 1'b0;
      tick();

      // Write r5 and issue r9, then async reset between edges
      regwrite = 1'b1; wn = 5'd5; wd = 32'hDEAD_BEEF; issue_en = 1'b1; issue_wn = 5'd9;
      tick();
      idle(); rn1 = 5'd5; rn2 = 5'd9;
      #1;
      chk("pre_rst_rd1", rd1_a, 32'hDEAD_BEEF);
      chk("pre_rst_busy2", {31'd0, busy2_a}, 32'd1);
      chk("pre_rst_cnt", {26'd0, pend_a}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_rd1", rd1_a, 32'd0);
      chk("async_rst_busy2", {31'd0, busy2_a}, 32'd0);
      chk("async_rst_cnt", {26'd0, pend_a}, 32'd0);
      rst = 1'b0;
      tick();

      // Zero register: write + issue r0
      regwrite = 1'b1; wn = 5'd0; wd = 32'h1234; issue_en = 1'b1; issue_wn = 5'd0; rn1 = 5'd0;
      tick();
      idle();
      #1;
      chk("zr_rd1", rd1_a, 32'd0);
      chk("zr_busy1", {31'd0, busy1_a}, 32'd0);
      chk("zr_cnt", {26'd0, pend_a}, 32'd0);
      chk("nozr_rd1", rd1_b, 32'h1234);
      chk("nozr_cnt", {26'd0, pend_b}, 32'd1);
      chk("nozr_busy1", {31'd0, busy1_b}, 32'd1);

      // Bypass: both ports on r7, write in flight
      rn1 = 5'd7; rn2 = 5'd7; regwrite = 1'b1; wn = 5'd7; wd = 32'hA5A5_A5A5;
      #1;
      chk("byp_rd1", rd1_a, 32'hA5A5_A5A5);
      chk("byp_rd2", rd2_a, 32'hA5A5_A5A5);
      chk("nobyp_rd1_old", rd1_b, 32'd0);
      chk("nobyp_rd2_old", rd2_b, 32'd0);
      tick();
      idle();
      #1;
      chk("nobyp_rd1_new", rd1_b, 32'hA5A5_A5A5);

      // Scoreboard: issue r3, then write it back
      issue_en = 1'b1; issue_wn = 5'd3;
      tick();
      idle(); rn1 = 5'd3; rn2 = 5'd3;
      #1;
      chk("sb_busy1", {31'd0, busy1_a}, 32'd1);
      chk("sb_cnt", {26'd0, pend_a}, 32'd1);
      chk("sb_cnt_b", {26'd0, pend_b}, 32'd2);
      regwrite = 1'b1; wn = 5'd3; wd = 32'h55;
      #1;
      chk("sb_wb_busy1", {31'd0, busy1_a}, 32'd0);
      chk("sb_wb_rd1", rd1_a, 32'h55);
      chk("sb_wb_busy2_nobyp", {31'd0, busy2_b}, 32'd1);
      tick();
      idle();
      #1;
      chk("sb_after_cnt", {26'd0, pend_a}, 32'd0);
      chk("sb_after_busy1", {31'd0, busy1_a}, 32'd0);

      // Same edge: issue r4 and write r4 -> stays pending with new data
      issue_en = 1'b1; issue_wn = 5'd4; regwrite = 1'b1; wn = 5'd4; wd = 32'h9;
      tick();
      idle(); rn1 = 5'd4;
      #1;
      chk("same_rd1", rd1_a, 32'h9);
      chk("same_busy1", {31'd0, busy1_a}, 32'd1);
      chk("same_cnt", {26'd0, pend_a}, 32'd1);

      // Issue r2, then issue r6 while writing back r2 -> count unchanged
      issue_en = 1'b1; issue_wn = 5'd2;
      tick();
      idle();
      #1;
      chk("pre_swap_cnt", {26'd0, pend_a}, 32'd2);
      issue_en = 1'b1; issue_wn = 5'd6; regwrite = 1'b1; wn = 5'd2; wd = 32'h77;
      tick();
      idle(); rn1 = 5'd6; rn2 = 5'd2;
      #1;
      chk("swap_cnt", {26'd0, pend_a}, 32'd2);
      chk("swap_busy_r6", {31'd0, busy1_a}, 32'd1);
      chk("swap_busy_r2", {31'd0, busy2_a}, 32'd0);
      chk("swap_rd_r2", rd2_a, 32'h77);

      // Saturation on the 8-entry instance
      rst = 1'b1;
      #1;
      rst = 1'b0;
      tick();
      for (int i = 1; i < 8; i++) begin
         issue_en = 1'b1; issue_wn = 5'(i);
         tick();
      end
      issue_en = 1'b1; issue_wn = 5'd5;
      tick();
      idle(); rn1 = 5'd7; rn2 = 5'd5;
      #1;
      chk("sat_cnt", {28'd0, pend_c}, 32'd7);
      chk("sat_busy1", {31'd0, busy1_c}, 32'd1);
      chk("sat_busy2", {31'd0, busy2_c}, 32'd1);
      chk("sat_cnt_a", {26'd0, pend_a}, 32'd7);
      for (int i = 1; i < 8; i++) begin
         regwrite = 1'b1; wn = 5'(i); wd = 32'(i * 17);
         tick();
      end
      idle();
      #1;
      chk("drain_cnt", {28'd0, pend_c}, 32'd0);
      chk("drain_rd1", rd1_c, 32'd119);
      chk("drain_rd2", rd2_c, 32'd85);
      chk("drain_busy1", {31'd0, busy1_c}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
